// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory stage: data-memory access, thread control, MEM/WB register
module mem_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr_mem,
    input  logic [31:0] pc_mem,
    input  logic [31:0] exe_data_mem,
    input  logic [2:0]  trd_mem,
    input  logic [4:0]  reg_wr_mem,
    input  logic        wr_en_mem,
    input  logic        wb_sel_mem,
    input  logic [1:0]  mem_ctrl_mem,
    input  logic [2:0]  trd_ctrl_mem,
    input  logic [2:0]  obj_trd_mem,
    input  logic [31:0] new_pc_mem,
    input  logic [31:0] new_data_mem,
    input  logic        flushMEM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        tc_req,
    output logic [1:0]  tc_op,
    output logic [2:0]  tc_trd,
    output logic [31:0] tc_pc,
    output logic [31:0] tc_data,
    input  logic        tc_ack,
    output logic        stall_mem,
    output logic [31:0] wb_data_wb,
    output logic [4:0]  reg_wr_wb,
    output logic        wr_en_wb,
    output logic [2:0]  trd_wb,
    output logic [31:0] pc_wb
);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, TC, DRAIN} state_t;

    state_t state, next_state;
    // Low from reset until the first edge after release; masks every request and stall.
    logic   active;
    logic   mem_op, thr_op, is_store;
    logic   mem_req_c, tc_req_c, retire, stall_c;

    // A memory op outranks a thread op if both happen to be encoded.
    assign mem_op   = (mem_ctrl_mem == 2'b01) || (mem_ctrl_mem == 2'b10);
    assign is_store = mem_ctrl_mem[1];
    assign thr_op   = !mem_op && ((trd_ctrl_mem == 3'b001) || (trd_ctrl_mem == 3'b010) ||
                                  (trd_ctrl_mem == 3'b011));

    // State register; reset aborts any outstanding access without tracking a drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            active <= 1'b0;
        end else begin
            state  <= next_state;
            active <= 1'b1;
        end
    end

    // Next-state logic for the access/thread-op sequencer.
    always_comb begin
        next_state = state;
        if (!active) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (flushMEM)
                        next_state = IDLE;
                    else if (mem_op)
                        next_state = dmem_gnt ? (is_store ? IDLE : WAIT) : REQ;
                    else if (thr_op)
                        next_state = tc_ack ? IDLE : TC;
                end
                REQ: begin
                    if (flushMEM)
                        next_state = IDLE;
                    else if (dmem_gnt)
                        next_state = is_store ? IDLE : WAIT;
                end
                WAIT: begin
                    // A flushed load still owes one rvalid; drain it unless it is here now.
                    if (flushMEM)
                        next_state = dmem_rvalid ? IDLE : DRAIN;
                    else if (dmem_rvalid)
                        next_state = IDLE;
                end
                TC: begin
                    if (flushMEM || tc_ack)
                        next_state = IDLE;
                end
                DRAIN: begin
                    if (dmem_rvalid)
                        next_state = IDLE;
                end
                default: next_state = IDLE;
            endcase
        end
    end

    // Output logic: requests, retire decision and stall.
    always_comb begin
        mem_req_c = 1'b0;
        tc_req_c  = 1'b0;
        retire    = 1'b0;
        stall_c   = 1'b0;
        if (active) begin
            case (state)
                IDLE: begin
                    if (!flushMEM) begin
                        if (mem_op) begin
                            mem_req_c = 1'b1;
                            retire    = dmem_gnt && is_store;
                        end else if (thr_op) begin
                            tc_req_c = 1'b1;
                            retire   = tc_ack;
                        end else begin
                            retire = 1'b1;
                        end
                        stall_c = (mem_op || thr_op) && !retire;
                    end
                end
                REQ: begin
                    if (!flushMEM) begin
                        mem_req_c = 1'b1;
                        retire    = dmem_gnt && is_store;
                        stall_c   = !retire;
                    end
                end
                WAIT: begin
                    if (flushMEM) begin
                        stall_c = !dmem_rvalid;
                    end else begin
                        retire  = dmem_rvalid;
                        stall_c = !dmem_rvalid;
                    end
                end
                TC: begin
                    if (!flushMEM) begin
                        tc_req_c = 1'b1;
                        retire   = tc_ack;
                        stall_c  = !tc_ack;
                    end
                end
                DRAIN: begin
                    stall_c = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign dmem_req   = mem_req_c;
    assign dmem_we    = mem_req_c && is_store;
    assign dmem_addr  = mem_req_c ? addr_mem : 32'h0;
    assign dmem_wdata = mem_req_c ? exe_data_mem : 32'h0;
    assign tc_req     = tc_req_c;
    assign tc_op      = tc_req_c ? trd_ctrl_mem[1:0] : 2'b00;
    assign tc_trd     = tc_req_c ? obj_trd_mem : 3'b000;
    assign tc_pc      = tc_req_c ? new_pc_mem : 32'h0;
    assign tc_data    = tc_req_c ? new_data_mem : 32'h0;
    assign stall_mem  = stall_c;

    // MEM/WB register: real instruction on retire, bubble otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_data_wb <= 32'h0;
            reg_wr_wb  <= 5'h0;
            wr_en_wb   <= 1'b0;
            trd_wb     <= 3'h0;
            pc_wb      <= 32'h0;
        end else if (retire) begin
            wb_data_wb <= wb_sel_mem ? dmem_rdata : exe_data_mem;
            reg_wr_wb  <= reg_wr_mem;
            wr_en_wb   <= wr_en_mem;
            trd_wb     <= trd_mem;
            pc_wb      <= pc_mem;
        end else begin
            wb_data_wb <= 32'h0;
            reg_wr_wb  <= 5'h0;
            wr_en_wb   <= 1'b0;
            trd_wb     <= 3'h0;
            pc_wb      <= 32'h0;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr_mem, pc_mem, exe_data_mem, new_pc_mem, new_data_mem, dmem_rdata;
    logic [2:0]  trd_mem, trd_ctrl_mem, obj_trd_mem;
    logic [4:0]  reg_wr_mem;
    logic        wr_en_mem, wb_sel_mem, flushMEM, dmem_gnt, dmem_rvalid, tc_ack;
    logic [1:0]  mem_ctrl_mem;
    logic        dmem_req, dmem_we, tc_req, stall_mem, wr_en_wb;
    logic [31:0] dmem_addr, dmem_wdata, tc_pc, tc_data, wb_data_wb, pc_wb;
    logic [1:0]  tc_op;
    logic [2:0]  tc_trd, trd_wb;
    logic [4:0]  reg_wr_wb;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .rst_n(rst_n),
        .addr_mem(addr_mem), .pc_mem(pc_mem), .exe_data_mem(exe_data_mem),
        .trd_mem(trd_mem), .reg_wr_mem(reg_wr_mem), .wr_en_mem(wr_en_mem),
        .wb_sel_mem(wb_sel_mem), .mem_ctrl_mem(mem_ctrl_mem), .trd_ctrl_mem(trd_ctrl_mem),
        .obj_trd_mem(obj_trd_mem), .new_pc_mem(new_pc_mem), .new_data_mem(new_data_mem),
        .flushMEM(flushMEM),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .tc_req(tc_req), .tc_op(tc_op), .tc_trd(tc_trd), .tc_pc(tc_pc), .tc_data(tc_data),
        .tc_ack(tc_ack), .stall_mem(stall_mem),
        .wb_data_wb(wb_data_wb), .reg_wr_wb(reg_wr_wb), .wr_en_wb(wr_en_wb),
        .trd_wb(trd_wb), .pc_wb(pc_wb)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        addr_mem = 0; pc_mem = 0; exe_data_mem = 0; trd_mem = 0; reg_wr_mem = 0;
        wr_en_mem = 0; wb_sel_mem = 0; mem_ctrl_mem = 0; trd_ctrl_mem = 0;
        obj_trd_mem = 0; new_pc_mem = 0; new_data_mem = 0; flushMEM = 0;
        dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0; tc_ack = 0;
    endtask

    initial begin
        clear_in();
        rst_n = 1'b0;
        mem_ctrl_mem = 2'b01; dmem_gnt = 1'b1; trd_ctrl_mem = 3'b001;
        #3;
        chk("rst_dmem_req", {31'b0, dmem_req}, 0);
        chk("rst_tc_req", {31'b0, tc_req}, 0);
        chk("rst_stall", {31'b0, stall_mem}, 0);
        chk("rst_wb_data", wb_data_wb, 0);
        chk("rst_wr_en_wb", {31'b0, wr_en_wb}, 0);
        #19 rst_n = 1'b1;
        #1;
        chk("post_release_req", {31'b0, dmem_req}, 0);
        chk("post_release_stall", {31'b0, stall_mem}, 0);
        cyc();
        clear_in();

        // ALU op
        exe_data_mem = 32'h1234; reg_wr_mem = 5; wr_en_mem = 1; trd_mem = 2; pc_mem = 32'h100;
        #1 chk("alu_stall", {31'b0, stall_mem}, 0);
        cyc();
        chk("alu_wb_data", wb_data_wb, 32'h1234);
        chk("alu_reg_wr", {27'b0, reg_wr_wb}, 5);
        chk("alu_trd", {29'b0, trd_wb}, 2);
        chk("alu_wr_en", {31'b0, wr_en_wb}, 1);
        chk("alu_pc", pc_wb, 32'h100);
        clear_in();

        // Store with grant withheld 3 cycles
        addr_mem = 32'h40; exe_data_mem = 32'hDEAD; mem_ctrl_mem = 2'b10; pc_mem = 32'h104;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("st_req", {31'b0, dmem_req}, 1);
            chk("st_we", {31'b0, dmem_we}, 1);
            chk("st_addr", dmem_addr, 32'h40);
            chk("st_wdata", dmem_wdata, 32'hDEAD);
            chk("st_stall", {31'b0, stall_mem}, 1);
            cyc();
            chk("st_bubble_pc", pc_wb, 0);
        end
        dmem_gnt = 1;
        #1 chk("st_gnt_stall", {31'b0, stall_mem}, 0);
        chk("st_gnt_req", {31'b0, dmem_req}, 1);
        cyc();
        chk("st_ret_pc", pc_wb, 32'h104);
        chk("st_ret_wr_en", {31'b0, wr_en_wb}, 0);
        clear_in();

        // Load, grant cycle 0, rvalid cycle 2; thread op encoded too and must be ignored
        addr_mem = 32'h80; wb_sel_mem = 1; mem_ctrl_mem = 2'b01; wr_en_mem = 1;
        reg_wr_mem = 7; trd_mem = 1; pc_mem = 32'h108; dmem_gnt = 1; trd_ctrl_mem = 3'b001;
        #1;
        chk("ld_req", {31'b0, dmem_req}, 1);
        chk("ld_we", {31'b0, dmem_we}, 0);
        chk("ld_tc_ignored", {31'b0, tc_req}, 0);
        chk("ld_stall0", {31'b0, stall_mem}, 1);
        cyc();
        dmem_gnt = 0;
        chk("ld_bubble0", {31'b0, wr_en_wb}, 0);
        #1 chk("ld_wait_req", {31'b0, dmem_req}, 0);
        chk("ld_stall1", {31'b0, stall_mem}, 1);
        cyc();
        chk("ld_bubble1", {31'b0, wr_en_wb}, 0);
        dmem_rvalid = 1; dmem_rdata = 32'hCAFEF00D;
        #1 chk("ld_stall2", {31'b0, stall_mem}, 0);
        cyc();
        chk("ld_wb_data", wb_data_wb, 32'hCAFEF00D);
        chk("ld_wr_en", {31'b0, wr_en_wb}, 1);
        chk("ld_reg_wr", {27'b0, reg_wr_wb}, 7);
        clear_in();

        // Spawn with ack in cycle 1
        trd_ctrl_mem = 3'b001; obj_trd_mem = 3; new_pc_mem = 32'h200; new_data_mem = 32'h55;
        pc_mem = 32'h10C;
        for (int i = 0; i < 2; i++) begin
            if (i == 1) tc_ack = 1;
            #1;
            chk("sp_req", {31'b0, tc_req}, 1);
            chk("sp_op", {30'b0, tc_op}, 1);
            chk("sp_trd", {29'b0, tc_trd}, 3);
            chk("sp_pc", tc_pc, 32'h200);
            chk("sp_data", tc_data, 32'h55);
            chk("sp_stall", {31'b0, stall_mem}, (i == 0) ? 1 : 0);
            cyc();
        end
        chk("sp_ret_pc", pc_wb, 32'h10C);
        clear_in();
        #1 chk("sp_req_drop", {31'b0, tc_req}, 0);

        // Flush in WAIT, rvalid two cycles later, next load waits for it
        addr_mem = 32'h90; wb_sel_mem = 1; mem_ctrl_mem = 2'b01; wr_en_mem = 1;
        reg_wr_mem = 9; pc_mem = 32'h110; dmem_gnt = 1;
        cyc();
        dmem_gnt = 0; flushMEM = 1;
        #1 chk("fl_wait_stall", {31'b0, stall_mem}, 1);
        cyc();
        flushMEM = 0; addr_mem = 32'hA0; pc_mem = 32'h114; reg_wr_mem = 10;
        #1 chk("fl_drain_req", {31'b0, dmem_req}, 0);
        chk("fl_drain_stall", {31'b0, stall_mem}, 1);
        chk("fl_bubble", {31'b0, wr_en_wb}, 0);
        cyc();
        dmem_rvalid = 1; dmem_rdata = 32'hBAD;
        #1 chk("fl_rv_req", {31'b0, dmem_req}, 0);
        chk("fl_rv_stall", {31'b0, stall_mem}, 1);
        cyc();
        chk("fl_no_wb", {31'b0, wr_en_wb}, 0);
        chk("fl_no_wb_data", wb_data_wb, 0);
        dmem_rvalid = 0; dmem_gnt = 1;
        #1 chk("fl_next_req", {31'b0, dmem_req}, 1);
        chk("fl_next_addr", dmem_addr, 32'hA0);
        cyc();
        dmem_gnt = 0; dmem_rvalid = 1; dmem_rdata = 32'h1111;
        cyc();
        chk("fl_next_wb", wb_data_wb, 32'h1111);
        chk("fl_next_reg", {27'b0, reg_wr_wb}, 10);
        clear_in();

        // Flush in REQ drops the request and the stall
        addr_mem = 32'h44; exe_data_mem = 32'h9; mem_ctrl_mem = 2'b10; pc_mem = 32'h118;
        cyc();
        flushMEM = 1;
        #1 chk("flreq_req", {31'b0, dmem_req}, 0);
        chk("flreq_stall", {31'b0, stall_mem}, 0);
        cyc();
        chk("flreq_bubble_pc", pc_wb, 0);
        clear_in();

        // Reset during WAIT, then a stray rvalid
        addr_mem = 32'hC0; mem_ctrl_mem = 2'b01; wb_sel_mem = 1; wr_en_mem = 1;
        reg_wr_mem = 4; pc_mem = 32'h11C; dmem_gnt = 1;
        cyc();
        dmem_gnt = 0;
        #1 chk("rw_wait_stall", {31'b0, stall_mem}, 1);
        #1 rst_n = 0;
        #1;
        chk("rw_stall", {31'b0, stall_mem}, 0);
        chk("rw_req", {31'b0, dmem_req}, 0);
        chk("rw_wb_data", wb_data_wb, 0);
        cyc();
        rst_n = 1;
        clear_in();
        cyc();
        exe_data_mem = 32'h77; reg_wr_mem = 3; wr_en_mem = 1; pc_mem = 32'h120;
        dmem_rvalid = 1; dmem_rdata = 32'h999;
        #1 chk("stray_stall", {31'b0, stall_mem}, 0);
        cyc();
        chk("stray_wb_data", wb_data_wb, 32'h77);
        chk("stray_reg", {27'b0, reg_wr_wb}, 3);
        clear_in();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the multithreaded pipeline. Consumes the EX/MEM register set produced by the execution stage and runs data-memory loads/stores over a request/grant/valid handshake. Issues thread-control operations (spawn, kill, set-data) to the thread manager, and registers the MEM/WB bundle whose `wb_data_wb`/`reg_wr_wb`/`wr_en_wb`/`trd_wb` feed execution-stage forwarding. While an access or thread operation is outstanding, `stall_mem` freezes the front of the pipeline.

## Interface
- No parameters; data width 32, register index 5, thread id 3.
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `addr_mem`, `pc_mem`, `exe_data_mem` in 32 each: effective address, instruction PC, ALU result or store data.
- `trd_mem` in 3: thread id. `reg_wr_mem` in 5: destination register. `wr_en_mem` in 1: register write enable.
- `wb_sel_mem` in 1: 1 = write back load data, 0 = write back `exe_data_mem`.
- `mem_ctrl_mem` in 2: 00 none, 01 load, 10 store, 11 treated as none.
- `trd_ctrl_mem` in 3: 000 none, 001 spawn, 010 kill, 011 set-data, others treated as none.
- `obj_trd_mem` in 3, `new_pc_mem` in 32, `new_data_mem` in 32: thread-control target, start PC, data word.
- `flushMEM` in 1: kill the instruction currently in MEM.
- `dmem_req` out 1, `dmem_we` out 1, `dmem_addr` out 32, `dmem_wdata` out 32: data-memory request.
- `dmem_gnt` in 1, `dmem_rvalid` in 1, `dmem_rdata` in 32: grant and read return.
- `tc_req` out 1, `tc_op` out 2 (01 spawn, 10 kill, 11 set-data), `tc_trd` out 3, `tc_pc` out 32, `tc_data` out 32: thread-manager request.
- `tc_ack` in 1: thread-manager acknowledge.
- `stall_mem` out 1: MEM cannot retire this cycle. While it is 1, upstream holds all `*_mem` inputs stable.
- `wb_data_wb` out 32, `reg_wr_wb` out 5, `wr_en_wb` out 1, `trd_wb` out 3, `pc_wb` out 32: MEM/WB register.

## Operation
- An instruction in MEM has a memory op if `mem_ctrl_mem` is 01 or 10, and a thread op if `trd_ctrl_mem` is 001, 010 or 011. It never has both; if both are encoded, the memory op wins and the thread op is ignored.
- FSM states: IDLE, REQ, WAIT, TC, DRAIN.
- IDLE, memory op: drive `dmem_req`=1 combinationally with `dmem_we`=`mem_ctrl_mem[1]`, `dmem_addr`=`addr_mem`, `dmem_wdata`=`exe_data_mem`.
  - Store with gnt: retire.
  - Load with gnt: go to WAIT.
  - No gnt: go to REQ.
- REQ: hold the request stable until `dmem_gnt`, then treat as in IDLE.
- WAIT: retire on `dmem_rvalid` and capture `dmem_rdata`.
- IDLE, thread op: drive `tc_req`=1 combinationally with `tc_trd`=`obj_trd_mem`, `tc_pc`=`new_pc_mem`, `tc_data`=`new_data_mem`. Retire on `tc_ack`; otherwise go to TC and hold until ack.
- No op: retire in the same cycle.
- `stall_mem` = (memory or thread op present) AND NOT (retiring this cycle).
- On retire, the clock edge loads the WB register from the `*_mem` inputs:
  - `wb_data_wb` = `wb_sel_mem` ? load data : `exe_data_mem`.
  - `wr_en_wb` = `wr_en_mem`.
- When not retiring, the WB register loads a bubble: `wr_en_wb`=0, `reg_wr_wb`=0, other fields 0.
- Flush:
  - `flushMEM` in IDLE/REQ/TC drops the request that cycle (`dmem_req`/`tc_req`=0), writes a bubble, goes to IDLE, and forces `stall_mem`=0.
  - In WAIT (load already granted) go to DRAIN. DRAIN discards the next `dmem_rvalid`, keeps `stall_mem`=1, and issues no new request until that rvalid arrives.
  - `flushMEM` in DRAIN has no additional effect.
- `dmem_rvalid` outside WAIT/DRAIN is ignored. `tc_ack` outside an active thread op is ignored.

## Timing
- Reset: state IDLE; all WB outputs 0. `dmem_req`, `tc_req` and `stall_mem` are 0 regardless of inputs until the first edge after release.
- No-op or ALU instruction: WB valid one edge after it enters MEM (1-cycle latency).
- Store with same-cycle gnt: 1 cycle. Each grant-wait cycle adds 1.
- Load with gnt in cycle 0 and rvalid in cycle k≥1: WB loads at the end of cycle k. `stall_mem`=1 for cycles 0..k-1 and 0 in cycle k.
- Thread op with same-cycle ack: 1 cycle.
- At most one outstanding memory transaction.
- Reset asserted mid-operation aborts immediately to IDLE; no drain is tracked.

## Test plan
- ALU op, `exe_data_mem`=0x1234, `reg_wr_mem`=5, `wr_en_mem`=1, `trd_mem`=2 -> next cycle `wb_data_wb`=0x1234, `reg_wr_wb`=5, `trd_wb`=2, `stall_mem` never 1.
- Store to 0x40 with data 0xDEAD, gnt withheld 3 cycles -> `dmem_req` held with `dmem_we`=1 and stable addr/data, `stall_mem`=1 for 3 cycles, retire on the 4th cycle, `wr_en_wb`=0.
- Load from 0x80, `wb_sel_mem`=1, gnt cycle 0, rvalid cycle 2 with 0xCAFEF00D -> `wb_data_wb`=0xCAFEF00D after cycle 2, bubbles written after cycles 0 and 1.
- Spawn: `obj_trd_mem`=3, `new_pc_mem`=0x200, ack in cycle 1 -> `tc_op`=01, `tc_trd`=3, `tc_pc`=0x200 for 2 cycles, `tc_req` drops after ack.
- Load granted, then `flushMEM` in WAIT, rvalid 2 cycles later -> no WB write, `stall_mem`=1 until rvalid, next load issues the cycle after rvalid.
- Reset asserted in WAIT -> all outputs 0 asynchronously; a later stray rvalid is ignored.
